// File: rtl/ibex_multdiv_timing_ctrl.sv
// Sequencing controller in front of the shared ibex multiplier/divider datapath.
// In data-independent timing mode it pads every result to a fixed per-class latency.
module ibex_multdiv_timing_ctrl #(
  parameter int unsigned MulCycles = 3,
  parameter int unsigned DivCycles = 37
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic [1:0]  req_op_i,
  input  logic        data_ind_timing_i,
  input  logic        kill_i,
  output logic        md_en_o,
  output logic        md_ready_o,
  input  logic        md_valid_i,
  input  logic [31:0] md_result_i,
  output logic        result_valid_o,
  input  logic        result_ready_i,
  output logic [31:0] result_o,
  output logic        busy_o,
  output logic        overrun_o
);

  typedef enum logic [1:0] {
    MD_OP_MULL = 2'b00,
    MD_OP_MULH = 2'b01,
    MD_OP_DIV  = 2'b10,
    MD_OP_REM  = 2'b11
  } md_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    HOLD = 2'b10,
    RESP = 2'b11
  } state_e;

  localparam logic [5:0] MulTarget = 6'(MulCycles);
  localparam logic [5:0] DivTarget = 6'(DivCycles);
  localparam logic [5:0] CntMax    = 6'd63;

  state_e      state_q, state_d;
  logic [5:0]  cnt_q, cnt_d;
  logic [5:0]  target_q, target_d;
  logic        dit_q, dit_d;
  logic [31:0] result_q, result_d;
  logic        overrun_q, overrun_d;

  md_op_e      op;
  logic        accept;
  logic [5:0]  cnt_inc;

  assign op          = md_op_e'(req_op_i);
  assign req_ready_o = (state_q == IDLE) && !kill_i;
  assign accept      = req_valid_i && req_ready_o;
  assign cnt_inc     = (cnt_q == CntMax) ? cnt_q : cnt_q + 6'd1;

  assign md_en_o        = (state_q == RUN);
  assign md_ready_o     = (state_q == RUN) && md_valid_i && !kill_i;
  assign result_valid_o = (state_q == RESP);
  assign busy_o         = (state_q != IDLE);
  assign result_o       = result_q;
  assign overrun_o      = overrun_q;

  // kill_i overrides every state; result and overrun flag survive it.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    target_d  = target_q;
    dit_d     = dit_q;
    result_d  = result_q;
    overrun_d = overrun_q;

    if (kill_i) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            state_d  = RUN;
            cnt_d    = 6'd1;
            target_d = (op == MD_OP_DIV || op == MD_OP_REM) ? DivTarget : MulTarget;
            dit_d    = data_ind_timing_i;
          end
        end
        RUN: begin
          cnt_d = cnt_inc;
          if (md_valid_i) begin
            result_d = md_result_i;
            if (dit_q && (cnt_q < target_q)) begin
              state_d = HOLD;
            end else begin
              state_d = RESP;
              if (dit_q && (cnt_q > target_q)) begin
                overrun_d = 1'b1;
              end
            end
          end else if (dit_q && (cnt_q == CntMax)) begin
            overrun_d = 1'b1;
          end
        end
        HOLD: begin
          cnt_d = cnt_inc;
          if (cnt_q >= target_q) begin
            state_d = RESP;
          end
        end
        RESP: begin
          if (result_ready_i) begin
            state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= IDLE;
      cnt_q     <= 6'd0;
      target_q  <= 6'd0;
      dit_q     <= 1'b0;
      result_q  <= 32'd0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      target_q  <= target_d;
      dit_q     <= dit_d;
      result_q  <= result_d;
      overrun_q <= overrun_d;
    end
  end

endmodule

// File: doc/ibex_multdiv_timing_ctrl.md
Name: ibex_multdiv_timing_ctrl

Overview:
- Sequencing controller in front of the shared ibex multiplier/divider datapath.
- Accepts one operation at a time and drives the multdiv enable.
- Captures the multdiv result and returns it with a valid/ready handshake.
- When data-independent timing is requested, holds the response so that result latency depends only on the operation class, never on operand values or early-out paths. Any operation that exceeds its fixed budget is flagged.

Parameters:
- MulCycles, 3, fixed RUN+HOLD cycle budget for MULL/MULH (range 1..62).
- DivCycles, 37, fixed RUN+HOLD cycle budget for DIV/REM (range 1..62).

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- req_valid_i  in  1  operation request
- req_ready_o  out  1  controller can accept a request
- req_op_i  in  2  ibex_pkg::md_op_e (MD_OP_MULL, MD_OP_MULH, MD_OP_DIV, MD_OP_REM)
- data_ind_timing_i  in  1  constant-latency mode, sampled at acceptance
- kill_i  in  1  flush; aborts any in-flight operation
- md_en_o  out  1  enable to the multdiv datapath
- md_ready_o  out  1  one-cycle acknowledge to multdiv on result capture
- md_valid_i  in  1  multdiv result valid
- md_result_i  in  32  multdiv result
- result_valid_o  out  1  response valid
- result_ready_i  in  1  consumer accepts response
- result_o  out  32  captured result
- busy_o  out  1  state != IDLE
- overrun_o  out  1  sticky: constant-latency budget exceeded

Behaviour:
- Reset (async, any state): state=IDLE, cnt=0, result_o=0, overrun_o=0; req_ready_o=1; all other outputs 0.
- State machine: IDLE, RUN, HOLD, RESP.
- Acceptance: a request is accepted when req_valid_i && req_ready_o. req_ready_o=1 only in IDLE, and is forced to 0 while kill_i=1.
- Latched at acceptance: target (MulCycles for MULL/MULH, DivCycles for DIV/REM) and dit=data_ind_timing_i. The cycle in which the request is accepted is cycle 0.
- IDLE -> RUN on acceptance; cnt<=1.
- RUN:
  - md_en_o=1. cnt increments each cycle, saturating at 63.
  - On md_valid_i: result_o<=md_result_i; md_ready_o=1 in that cycle; md_en_o drops next cycle.
  - Next state after capture:
    - dit && cnt<target -> HOLD.
    - dit && cnt>target -> RESP, overrun_o<=1.
    - Otherwise -> RESP.
  - If dit, cnt reaches 63 and md_valid_i is still 0: overrun_o<=1 and the controller keeps waiting.
- HOLD: md_en_o=0; cnt increments; when cnt==target -> RESP.
- RESP:
  - result_valid_o=1; result_o is stable.
  - On result_ready_i -> IDLE.
  - result_valid_o never drops without a handshake, except on kill_i.
- Latency:
  - dit=1: result_valid_o first asserts in cycle target+1, independent of the md_valid_i timing within budget.
  - dit=0: result_valid_o asserts in cycle k+1, where md_valid_i arrived in cycle k.
- Throughput: at least one bubble between operations, because IDLE is mandatory after RESP.
- kill_i: highest priority in every state. Next state is IDLE, and md_en_o=0 from the next cycle. result_o and overrun_o are retained. kill_i together with md_valid_i means kill wins: no capture, md_ready_o=0.
- overrun_o is cleared only by reset.
- data_ind_timing_i and req_op_i changes after acceptance have no effect.
- Reset mid-operation: immediate return to IDLE. No residual md_en_o or result_valid_o.

Test Plan:
- DIT mul: dit=1, MULL, md_valid_i in cycle 2, result 0x0000_0006 -> HOLD for 1 cycle; result_valid_o rises in cycle 4; md_ready_o pulses in cycle 2.
- DIT div early-out: dit=1, DIV, md_valid_i in cycle 5 (divide by zero) -> result_valid_o rises exactly in cycle 38. Repeating with md_valid_i in cycle 37 gives the same cycle 38; overrun_o stays 0.
- Non-DIT: dit=0, REM, md_valid_i in cycle 5 -> result_valid_o in cycle 6; result_o=md_result_i captured in cycle 5.
- Overrun: dit=1, MULH, md_valid_i in cycle 5 -> overrun_o=1 from cycle 6 and stays 1 through later operations until reset.
- Backpressure and kill:
  - result_ready_i held 0 for 10 cycles in RESP -> result_valid_o and result_o stable; req_ready_o=0.
  - kill_i asserted in a HOLD cycle -> IDLE next cycle, no result_valid_o.
  - kill_i coincident with md_valid_i -> no capture.
- Async reset: rst_ni pulsed low mid-RUN of a DIV -> all outputs at reset values immediately; a new MULL accepted after release completes normally in cycle 4 (dit=1).
